regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between NREQ writeback requesters, e.g. ALU writeback and load/memory writeback.
- Arbitrates round-robin and registers the winner.
- Drives the write-enable/address/data lines that feed the register file's write-select decoder enable and select inputs.
- Handles writeback stall and suppresses writes to the hardwired zero register.

Parameters:
NREQ, 2, number of writeback requesters (>=2)
ADDR_WIDTH, 5, register address width; decoder selects 2**ADDR_WIDTH registers
DATA_WIDTH, 64, register data width
ZERO_REG, 31, address of the hardwired zero register; writes to it are dropped

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester write request
req_addr  input  NREQ*ADDR_WIDTH  destination register, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  input  NREQ*DATA_WIDTH  write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NREQ  one-hot grant; request i is accepted when req_valid[i] & req_ready[i]
wr_stall  input  1  register file port unavailable this cycle
wr_enable  output  1  to decoder enable; high commits wr_data to wr_addr at this edge
wr_addr  output  ADDR_WIDTH  to decoder select input
wr_data  output  DATA_WIDTH  write data
wr_grant_id  output  $clog2(NREQ)  index of requester owning the current wr_* contents

Behaviour:
- Reset (synchronous, active-high): wr_enable=0, wr_addr=0, wr_data=0, wr_grant_id=0, state=IDLE, last_grant=NREQ-1 so requester 0 has first priority. reset dominates all other inputs, including mid-HOLD; a held write is discarded, not committed.
- req_ready is combinational from req_valid, last_grant, state and wr_stall. It is at most one-hot and is never high for a requester with req_valid=0.
- Round-robin: search starts at (last_grant+1) mod NREQ and wraps; first valid requester wins. last_grant updates only on acceptance.
- No grant while wr_stall=1 or while state=HOLD. req_ready is all-zero then.
- Latency: a request accepted at edge N appears on wr_* after edge N and commits at edge N+1 (1 cycle).
- Zero register: a request with addr==ZERO_REG is accepted normally (ready, pointer advance) but loads wr_enable=0. wr_addr/wr_data still load for visibility.
- FSM:
  - IDLE: wr_enable=0. On acceptance -> WRITE. Otherwise stay.
  - WRITE: output register holds a write. At the edge:
    - wr_stall=1 -> HOLD; wr_* frozen.
    - else, new acceptance -> WRITE with new contents (back-to-back, 1 write/cycle).
    - else -> IDLE with wr_enable=0.
  - HOLD: wr_* frozen and wr_enable held. On the first edge with wr_stall=0 -> IDLE, with no grant that cycle. This guarantees a held write is never overwritten before commit.
- A write is considered committed on the edge where state=WRITE and wr_stall=0, or state=HOLD and wr_stall=0.
- Same address from two requesters in one cycle: serialized in round-robin order. The later grant commits last and wins.
- Requester must hold req_valid/addr/data stable until accepted. Dropping req_valid before accept is legal; the request is simply lost, with no state change.
- Width rules: all fields pass through unmodified, no truncation. wr_grant_id is zero-extended index.

Test Plan:
1. Reset then idle: hold reset 2 cycles with req_valid=2'b11 -> req_ready=0, wr_enable=0, wr_addr=0 throughout reset. The first cycle after reset, req_ready=2'b01.
2. Contention: req_valid=2'b11 continuously, req0 addr=3 data=0xAAAA, req1 addr=4 data=0xBBBB.
   - Grants alternate 01,10,01.
   - wr_addr sequence is 3,4,3 one cycle later with wr_enable=1 each cycle.
   - wr_grant_id is 0,1,0.
3. Stall: req0 accepted with addr=7 data=0x1234, then wr_stall=1 for 3 cycles.
   - wr_enable=1, wr_addr=7, wr_data=0x1234 stable all 3 cycles, req_ready=0.
   - After stall drops: one commit edge, then IDLE with no grant that cycle, then grants resume.
4. Zero register: req1 valid addr=31 data=0xFFFF -> req_ready[1]=1 and wr_enable=0 next cycle. The next contention cycle grants req0, proving the pointer advanced.
5. Reset mid-HOLD: write to addr=9 held under wr_stall, assert reset for 1 cycle -> wr_enable=0 and state=IDLE after that edge. Requester 0 has priority again.
6. Same-address race: req0 addr=5 data=0x11 and req1 addr=5 data=0x22 in the same cycle, last_grant=1. Commits are 0x11 then 0x22, so the final value of register 5 is 0x22.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between the writeback requesters and the register-file
// write arbiter.
//   req_valid/req_addr/req_data : per-requester write requests (flat-packed)
//   req_ready                   : one-hot grant back to the requesters
//   wr_stall                    : register file cannot take a write this cycle
//   wr_enable/wr_addr/wr_data   : registered write toward the decoder
//   wr_grant_id                 : requester owning the current wr_* contents
// Handshake: request i transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. A requester keeps valid/addr/data stable until
// then. It may drop valid early, in which case the request is discarded.
interface regfile_write_arbiter_if #(
   parameter int NREQ       = 2,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64
);
   localparam int GRANT_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]            req_valid;
   logic [NREQ*ADDR_WIDTH-1:0] req_addr;
   logic [NREQ*DATA_WIDTH-1:0] req_data;
   logic [NREQ-1:0]            req_ready;
   logic                       wr_stall;
   logic                       wr_enable;
   logic [ADDR_WIDTH-1:0]      wr_addr;
   logic [DATA_WIDTH-1:0]      wr_data;
   logic [GRANT_W-1:0]         wr_grant_id;

   // Requester / register-file side.
   modport master (
      output req_valid, req_addr, req_data, wr_stall,
      input  req_ready, wr_enable, wr_addr, wr_data, wr_grant_id
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_addr, req_data, wr_stall,
      output req_ready, wr_enable, wr_addr, wr_data, wr_grant_id
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// NREQ writeback requesters. The winner is registered onto wr_* and commits
// on the following edge unless wr_stall holds it. Writes to ZERO_REG are
// accepted but never enabled.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   bus       : regfile_write_arbiter_if.slave (requests, grant, write port)
//   state_dbg : current FSM state (0=IDLE, 1=WRITE, 2=HOLD)
module regfile_write_arbiter #(
   parameter int NREQ       = 2,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64,
   parameter int ZERO_REG   = 31
) (
   input  logic                          clk,
   input  logic                          reset,
   regfile_write_arbiter_if.slave        bus,
   output logic [1:0]                    state_dbg
);
   localparam int GRANT_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t               state, state_next;
   logic [GRANT_W-1:0]   last_grant;
   logic [NREQ-1:0]      grant_onehot;
   logic [GRANT_W-1:0]   grant_idx;
   logic                 grant_found;
   logic                 grant_allowed;
   logic                 accept;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   int                   idx;

   // HOLD must drain before any new grant so a held write is never
   // overwritten ahead of its commit.
   assign grant_allowed = !reset && !bus.wr_stall && (state != HOLD);

   // Search starts one past the last winner and wraps.
   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      grant_found  = 1'b0;
      idx          = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_grant) + k) % NREQ;
         if (!grant_found && bus.req_valid[idx]) begin
            grant_found       = 1'b1;
            grant_onehot[idx] = 1'b1;
            grant_idx         = GRANT_W'(idx);
         end
      end
      if (!grant_allowed) begin
         grant_onehot = '0;
         grant_found  = 1'b0;
      end
   end

   assign accept        = grant_found;
   assign bus.req_ready = grant_onehot;
   assign sel_addr      = bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_data      = bus.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign state_dbg     = state;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = WRITE;
         WRITE: begin
            if (bus.wr_stall)  state_next = HOLD;
            else if (accept)   state_next = WRITE;
            else               state_next = IDLE;
         end
         HOLD:    if (!bus.wr_stall) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         last_grant      <= GRANT_W'(NREQ - 1);
         bus.wr_enable   <= 1'b0;
         bus.wr_addr     <= '0;
         bus.wr_data     <= '0;
         bus.wr_grant_id <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            last_grant      <= grant_idx;
            bus.wr_addr     <= sel_addr;
            bus.wr_data     <= sel_data;
            bus.wr_grant_id <= grant_idx;
            // Zero-register writes still load address/data for visibility.
            bus.wr_enable   <= (sel_addr != ADDR_WIDTH'(ZERO_REG));
         end else if (!bus.wr_stall) begin
            // Pending write (if any) commits at this edge; nothing replaces it.
            bus.wr_enable <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
   localparam int NREQ = 2;
   localparam int AW   = 5;
   localparam int DW   = 64;
   localparam int CW   = AW + DW;

   typedef struct {
      logic        rst;
      logic        stall;
      logic [1:0]  valid;
      logic [4:0]  a0;
      logic [63:0] d0;
      logic [4:0]  a1;
      logic [63:0] d1;
      logic [1:0]  rdy;
      logic        en;
      logic [4:0]  addr;
      logic [63:0] data;
      logic        gid;
      logic [1:0]  st;
   } vec_t;

   logic        clk;
   logic        reset;
   logic [1:0]  state_dbg;
   int          checks;
   int          errors;
   vec_t        vecs[24];
   logic [CW-1:0] exp_q[$];
   logic [63:0] rf[32];

   regfile_write_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   regfile_write_arbiter #(
      .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG(31)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .state_dbg(state_dbg)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic rst, logic stall, logic [1:0] valid,
                               logic [4:0] a0, logic [63:0] d0,
                               logic [4:0] a1, logic [63:0] d1,
                               logic [1:0] rdy, logic en, logic [4:0] addr,
                               logic [63:0] data, logic gid, logic [1:0] st);
      vec_t v;
      v.rst = rst; v.stall = stall; v.valid = valid;
      v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
      v.rdy = rdy; v.en = en; v.addr = addr; v.data = data; v.gid = gid; v.st = st;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Driver: one vector = one clock cycle. Ready is checked mid-cycle, the
   // registered outputs just after the rising edge. Commits are observed from
   // the pins (enable high, no stall, no reset) and scored against exp_q.
   task automatic apply(input vec_t v, input int n);
      logic          commit_now;
      logic [CW-1:0] commit_val;
      logic [CW-1:0] exp_val;
      @(negedge clk);
      reset         = v.rst;
      bus.wr_stall  = v.stall;
      bus.req_valid = v.valid;
      bus.req_addr  = {v.a1, v.a0};
      bus.req_data  = {v.d1, v.d0};
      #1;
      check($sformatf("v%0d ready", n), 64'(bus.req_ready), 64'(v.rdy));
      commit_now = bus.wr_enable && !bus.wr_stall && !reset;
      commit_val = {bus.wr_addr, bus.wr_data};
      @(posedge clk);
      #1;
      if (commit_now) begin
         rf[commit_val[CW-1:DW]] = commit_val[DW-1:0];
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d commit: unexpected commit 0x%0h, expected none", n, commit_val);
         end else begin
            exp_val = exp_q.pop_front();
            check($sformatf("v%0d commit_addr", n), 64'(commit_val[CW-1:DW]), 64'(exp_val[CW-1:DW]));
            check($sformatf("v%0d commit_data", n), commit_val[DW-1:0], exp_val[DW-1:0]);
         end
      end
      check($sformatf("v%0d wr_enable", n), 64'(bus.wr_enable), 64'(v.en));
      check($sformatf("v%0d wr_addr", n), 64'(bus.wr_addr), 64'(v.addr));
      check($sformatf("v%0d wr_data", n), bus.wr_data, v.data);
      check($sformatf("v%0d wr_grant_id", n), 64'(bus.wr_grant_id), 64'(v.gid));
      check($sformatf("v%0d state", n), 64'(state_dbg), 64'(v.st));
   endtask

   function automatic logic [CW-1:0] cv(logic [4:0] a, logic [63:0] d);
      return {a, d};
   endfunction

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b1;
      bus.wr_stall  = 1'b0;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;

      //            rst stall valid a0  d0        a1  d1        rdy   en addr data      gid st
      // Reset held with both requesters valid
      vecs[0]  = mk(1, 0, 2'b11, 3,  64'hAAAA, 4,  64'hBBBB, 2'b00, 0, 0,  64'h0,    0, 0);
      vecs[1]  = mk(1, 0, 2'b11, 3,  64'hAAAA, 4,  64'hBBBB, 2'b00, 0, 0,  64'h0,    0, 0);
      // Contention: alternate 0,1,0
      vecs[2]  = mk(0, 0, 2'b11, 3,  64'hAAAA, 4,  64'hBBBB, 2'b01, 1, 3,  64'hAAAA, 0, 1);
      vecs[3]  = mk(0, 0, 2'b11, 3,  64'hAAAA, 4,  64'hBBBB, 2'b10, 1, 4,  64'hBBBB, 1, 1);
      vecs[4]  = mk(0, 0, 2'b11, 3,  64'hAAAA, 4,  64'hBBBB, 2'b01, 1, 3,  64'hAAAA, 0, 1);
      vecs[5]  = mk(0, 0, 2'b00, 3,  64'hAAAA, 4,  64'hBBBB, 2'b00, 0, 3,  64'hAAAA, 0, 0);
      // Stall: write to 7 held 3 cycles, req1 waiting
      vecs[6]  = mk(0, 0, 2'b01, 7,  64'h1234, 0,  64'h0,    2'b01, 1, 7,  64'h1234, 0, 1);
      vecs[7]  = mk(0, 1, 2'b10, 0,  64'h0,    8,  64'h5555, 2'b00, 1, 7,  64'h1234, 0, 2);
      vecs[8]  = mk(0, 1, 2'b10, 0,  64'h0,    8,  64'h5555, 2'b00, 1, 7,  64'h1234, 0, 2);
      vecs[9]  = mk(0, 1, 2'b10, 0,  64'h0,    8,  64'h5555, 2'b00, 1, 7,  64'h1234, 0, 2);
      vecs[10] = mk(0, 0, 2'b10, 0,  64'h0,    8,  64'h5555, 2'b00, 0, 7,  64'h1234, 0, 0);
      vecs[11] = mk(0, 0, 2'b10, 0,  64'h0,    8,  64'h5555, 2'b10, 1, 8,  64'h5555, 1, 1);
      vecs[12] = mk(0, 0, 2'b01, 2,  64'h0202, 0,  64'h0,    2'b01, 1, 2,  64'h0202, 0, 1);
      // Zero register: accepted, not enabled, pointer advances
      vecs[13] = mk(0, 0, 2'b10, 0,  64'h0,    31, 64'hFFFF, 2'b10, 0, 31, 64'hFFFF, 1, 1);
      vecs[14] = mk(0, 0, 2'b11, 3,  64'hAAAA, 4,  64'hBBBB, 2'b01, 1, 3,  64'hAAAA, 0, 1);
      vecs[15] = mk(0, 0, 2'b00, 3,  64'hAAAA, 4,  64'hBBBB, 2'b00, 0, 3,  64'hAAAA, 0, 0);
      // Reset mid-HOLD discards the write to 9
      vecs[16] = mk(0, 0, 2'b01, 9,  64'h9999, 0,  64'h0,    2'b01, 1, 9,  64'h9999, 0, 1);
      vecs[17] = mk(0, 1, 2'b00, 9,  64'h9999, 0,  64'h0,    2'b00, 1, 9,  64'h9999, 0, 2);
      vecs[18] = mk(1, 1, 2'b00, 9,  64'h9999, 0,  64'h0,    2'b00, 0, 0,  64'h0,    0, 0);
      vecs[19] = mk(0, 0, 2'b11, 3,  64'hAAAA, 4,  64'hBBBB, 2'b01, 1, 3,  64'hAAAA, 0, 1);
      // Same-address race with last_grant=1
      vecs[20] = mk(0, 0, 2'b10, 0,  64'h0,    6,  64'h66,   2'b10, 1, 6,  64'h66,   1, 1);
      vecs[21] = mk(0, 0, 2'b11, 5,  64'h11,   5,  64'h22,   2'b01, 1, 5,  64'h11,   0, 1);
      vecs[22] = mk(0, 0, 2'b10, 5,  64'h11,   5,  64'h22,   2'b10, 1, 5,  64'h22,   1, 1);
      vecs[23] = mk(0, 0, 2'b00, 0,  64'h0,    0,  64'h0,    2'b00, 0, 5,  64'h22,   1, 0);

      // Expected commits, in order (the held write to 9 and the zero-register
      // write never appear).
      exp_q.push_back(cv(3, 64'hAAAA));
      exp_q.push_back(cv(4, 64'hBBBB));
      exp_q.push_back(cv(3, 64'hAAAA));
      exp_q.push_back(cv(7, 64'h1234));
      exp_q.push_back(cv(8, 64'h5555));
      exp_q.push_back(cv(2, 64'h0202));
      exp_q.push_back(cv(3, 64'hAAAA));
      exp_q.push_back(cv(3, 64'hAAAA));
      exp_q.push_back(cv(6, 64'h66));
      exp_q.push_back(cv(5, 64'h11));
      exp_q.push_back(cv(5, 64'h22));
      exp_q.push_back(cv(12, 64'hC));

      for (int i = 0; i < 24; i++) apply(vecs[i], i);

      // Hand-written: request offered only while stalled, then dropped, is lost.
      apply(mk(0, 1, 2'b01, 12, 64'hC, 0,  64'h0, 2'b00, 0, 5,  64'h22, 1, 0), 24);
      apply(mk(0, 0, 2'b00, 12, 64'hC, 0,  64'h0, 2'b00, 0, 5,  64'h22, 1, 0), 25);
      // Re-offered with contention: last_grant is still 1, so req0 wins.
      apply(mk(0, 0, 2'b11, 12, 64'hC, 13, 64'hD, 2'b01, 1, 12, 64'hC,  0, 1), 26);
      apply(mk(0, 0, 2'b00, 0,  64'h0, 0,  64'h0, 2'b00, 0, 12, 64'hC,  0, 0), 27);

      // Final register-file contents
      check("rf5_final", rf[5], 64'h22);
      check("rf9_discarded", rf[9], 64'h0);
      check("rf31_untouched", rf[31], 64'h0);
      check("commits_pending", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
